amp_pwr_mgr: RTL and testbench
==============================

# amp_pwr_mgr

Parametrised power-sequencing and fault manager for `NUM_AMPS` class-D amplifier channels. It sits beside `spkr_drv` at the Equalizer top level and replaces the inline `sht_dwn`/`Flt_n` counter logic. Per channel it:
- holds shutdown asserted for a programmable time after reset;
- debounces the amplifier fault line;
- retries a bounded number of times, then latches the channel off until software or a button clears it.

It also produces a mute request for the audio path.

## Interface
Parameters:
- `NUM_AMPS`, 2: number of independent amplifier channels.
- `HOLD_CYC`, 250000: shutdown hold time in clk cycles (5 ms at 50 MHz).
- `DEB_CYC`, 16: consecutive synchronized-low samples required to accept a fault.
- `MAX_RETRY`, 3: faults accepted (each followed by re-hold) before latch-off.
- `OK_CYC`, 50000000: clean RUN cycles after which the retry count clears (1 s).

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: asynchronous active-low reset; already synchronized by `rst_synch`.
- `Flt_n` in `NUM_AMPS`: asynchronous active-low amp fault lines, one per channel.
- `clr_latch` in 1: single-cycle pulse; releases every LATCHED channel.
- `sht_dwn` out `NUM_AMPS`: active-high amp shutdown, registered.
- `amp_ok` out `NUM_AMPS`: channel in RUN, registered.
- `latched` out `NUM_AMPS`: channel in LATCHED, registered.
- `fault_evt` out `NUM_AMPS`: one-cycle pulse when a fault is accepted in RUN.
- `mute` out 1: OR of `sht_dwn`, registered; drives the speaker-driver mute.

## Operation
- **Reset.** The design has one clock and an asynchronous active-low reset. Reset values:
  - `sht_dwn` = all 1s; `mute` = 1.
  - `amp_ok`, `latched`, `fault_evt` = 0.
  - All channels in HOLD; all counters = 0; retry counts = 0.
  - Synchronizer flops = 1 (no fault).
- **Synchronizer.** Each `Flt_n` bit passes through a 2-flop synchronizer.
- **Debounce.** Each channel has a counter of width `$clog2(DEB_CYC+1)`.
  - It increments while the synchronized `Flt_n` is 0 and saturates at `DEB_CYC`.
  - It clears to 0 on any synchronized 1.
  - `flt` means debounce counter == `DEB_CYC`.
- **Per-channel FSM.** States are HOLD, RUN, LATCHED. Each channel has one shared timer of width `$clog2(max(HOLD_CYC,OK_CYC)+1)` and a retry counter of width `$clog2(MAX_RETRY+1)`.
  - **HOLD** (`sht_dwn`=1):
    - If `flt`, the timer is held at 0.
    - Otherwise the timer increments.
    - When timer == `HOLD_CYC-1` and not `flt`: go to RUN, timer := 0.
  - **RUN** (`sht_dwn`=0, `amp_ok`=1):
    - On `flt` with retry < `MAX_RETRY`: retry++, pulse `fault_evt`, go to HOLD, timer := 0.
    - On `flt` with retry == `MAX_RETRY`: pulse `fault_evt`, go to LATCHED.
    - Otherwise the timer increments. When timer == `OK_CYC-1`: retry := 0 and timer saturates (stops).
  - **LATCHED** (`sht_dwn`=1, `latched`=1):
    - On `clr_latch`: go to HOLD, timer := 0, retry := 0.
    - `flt` is ignored in this state.
- **Channel independence.** Channels are fully independent. A fault on one channel never touches another channel's state.
- **`mute`.** Registered OR of the next-state `sht_dwn` bits. It asserts on the same edge as any `sht_dwn` and deasserts only when all channels are in RUN.
- **Simultaneous events.**
  - `clr_latch` in a non-LATCHED state has no effect.
  - `flt` in the same cycle as the HOLD terminal count keeps the channel in HOLD with timer := 0.
  - Several channels faulting in the same cycle each pulse their own `fault_evt` bit.
- **Reset mid-operation.** Any `rst_n` low forces the reset values immediately, asynchronously. LATCHED and retry state are lost.

## Timing
- **After reset release.** `sht_dwn` deasserts at the `HOLD_CYC`-th rising clk edge after the first edge with `rst_n`=1. `amp_ok` and `mute` change on that same edge.
- **Fault latency.**
  - Let `Flt_n` fall before edge k and stay low.
  - The synchronized low is seen at edge k+2.
  - `flt` is true after edge k+1+`DEB_CYC`.
  - `sht_dwn`, `fault_evt` and `mute` assert at edge k+2+`DEB_CYC`.
- **Glitches.** A low pulse shorter than `DEB_CYC` synchronized cycles produces no response.
- **`clr_latch` latency.** `clr_latch` sampled at edge j puts the channel in HOLD at edge j. `sht_dwn` then falls at edge j+`HOLD_CYC`, provided no fault occurs.
- **Registered outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Sim parameters for all scenarios: `NUM_AMPS`=2, `HOLD_CYC`=20, `DEB_CYC`=4, `MAX_RETRY`=2, `OK_CYC`=50.
1. **Power-up.** Release `rst_n` with `Flt_n`=2'b11 → `sht_dwn`=2'b11 for exactly 20 cycles, then 2'b00. `amp_ok`=2'b11 and `mute`=0 on the same edge.
2. **Glitch and real fault on channel 0.**
   - A 3-cycle low on `Flt_n[0]` in RUN → no change.
   - A 10-cycle low → `fault_evt[0]` pulses once and `sht_dwn[0]` rises 6 edges after the fall, while channel 1 stays in RUN.
   - `sht_dwn[0]` stays high 20 cycles after `Flt_n[0]` returns high plus the debounce drain.
3. **Latch-off.** Three accepted faults on channel 1, each less than 50 RUN cycles apart → `latched`=2'b10 and `sht_dwn[1]` stays 1 indefinitely. A `clr_latch` pulse → `sht_dwn[1]` falls 20 cycles later and retry resets.
4. **Retry decay.** Two faults, then more than 50 clean RUN cycles, then two more faults → channel never latches.
5. **Simultaneous events.**
   - Both `Flt_n` bits fall together → both `fault_evt` bits pulse in the same cycle.
   - `clr_latch` while in RUN → no effect.
6. **Reset mid-HOLD and while LATCHED.** Assert `rst_n` low → all outputs take reset values asynchronously, without waiting for a clk edge. Re-release → the 20-cycle hold restarts with retry=0.

Source files
------------

// File: rtl/amp_pwr_mgr.sv
// Power-sequencing and fault manager for NUM_AMPS class-D amplifier channels.
// Each channel has a shutdown hold, a debounced fault input, bounded retries and a latch-off state.
module amp_pwr_mgr #(
   parameter int NUM_AMPS  = 2,
   parameter int HOLD_CYC  = 250000,
   parameter int DEB_CYC   = 16,
   parameter int MAX_RETRY = 3,
   parameter int OK_CYC    = 50000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_AMPS-1:0] Flt_n,
   input  logic                clr_latch,
   output logic [NUM_AMPS-1:0] sht_dwn,
   output logic [NUM_AMPS-1:0] amp_ok,
   output logic [NUM_AMPS-1:0] latched,
   output logic [NUM_AMPS-1:0] fault_evt,
   output logic                mute
);

   localparam int TMR_MAX = (HOLD_CYC > OK_CYC) ? HOLD_CYC : OK_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int DW      = $clog2(DEB_CYC + 1);
   localparam int RW      = $clog2(MAX_RETRY + 1);

   localparam logic [TW-1:0] HOLD_END  = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] OK_END    = TW'(OK_CYC - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RUN     = 2'd1,
      S_LATCHED = 2'd2
   } state_t;

   logic [NUM_AMPS-1:0] r_sync1;
   logic [NUM_AMPS-1:0] r_sync2;
   logic [NUM_AMPS-1:0] w_sht_next;
   logic [NUM_AMPS-1:0] w_ok_next;
   logic [NUM_AMPS-1:0] w_lat_next;
   logic [NUM_AMPS-1:0] w_evt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= Flt_n;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_AMPS; gi++) begin : g_chan
         logic [DW-1:0] r_deb_cnt;
         logic [TW-1:0] r_tmr;
         logic [TW-1:0] w_tmr_next;
         logic [RW-1:0] r_retry;
         logic [RW-1:0] w_retry_next;
         state_t        r_state;
         state_t        w_state_next;
         logic          w_flt;
         logic          w_evt;

         assign w_flt = (r_deb_cnt == DEB_MAX);

         // Saturating low-sample counter; any synchronized high restarts the debounce.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_deb_cnt <= '0;
            end else if (r_sync2[gi]) begin
               r_deb_cnt <= '0;
            end else if (!w_flt) begin
               r_deb_cnt <= r_deb_cnt + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_state <= S_HOLD;
               r_tmr   <= '0;
               r_retry <= '0;
            end else begin
               r_state <= w_state_next;
               r_tmr   <= w_tmr_next;
               r_retry <= w_retry_next;
            end
         end

         always_comb begin
            w_state_next = r_state;
            w_tmr_next   = r_tmr;
            w_retry_next = r_retry;
            w_evt        = 1'b0;
            unique case (r_state)
               S_HOLD: begin
                  if (w_flt) begin
                     w_tmr_next = '0;
                  end else if (r_tmr == HOLD_END) begin
                     w_state_next = S_RUN;
                     w_tmr_next   = '0;
                  end else begin
                     w_tmr_next = r_tmr + 1'b1;
                  end
               end
               S_RUN: begin
                  if (w_flt) begin
                     w_evt = 1'b1;
                     if (r_retry < RETRY_MAX) begin
                        w_retry_next = r_retry + 1'b1;
                        w_state_next = S_HOLD;
                        w_tmr_next   = '0;
                     end else begin
                        w_state_next = S_LATCHED;
                     end
                  end else if (r_tmr == OK_END) begin
                     // Long clean run: forgive earlier faults, timer parks here.
                     w_retry_next = '0;
                  end else begin
                     w_tmr_next = r_tmr + 1'b1;
                  end
               end
               S_LATCHED: begin
                  if (clr_latch) begin
                     w_state_next = S_HOLD;
                     w_tmr_next   = '0;
                     w_retry_next = '0;
                  end
               end
               default: begin
                  w_state_next = S_HOLD;
                  w_tmr_next   = '0;
               end
            endcase
         end

         assign w_sht_next[gi] = (w_state_next != S_RUN);
         assign w_ok_next[gi]  = (w_state_next == S_RUN);
         assign w_lat_next[gi] = (w_state_next == S_LATCHED);
         assign w_evt_next[gi] = w_evt;
      end
   endgenerate

   // Outputs are registered copies of the next-state decode so they move on the transition edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sht_dwn   <= '1;
         amp_ok    <= '0;
         latched   <= '0;
         fault_evt <= '0;
         mute      <= 1'b1;
      end else begin
         sht_dwn   <= w_sht_next;
         amp_ok    <= w_ok_next;
         latched   <= w_lat_next;
         fault_evt <= w_evt_next;
         mute      <= |w_sht_next;
      end
   end

endmodule

// File: tb/tb_amp_pwr_mgr.sv
// Directed self-checking bench for amp_pwr_mgr with small sim parameters.
// Outputs are sampled 1 ns after each rising edge; inputs are also changed there.
module tb_amp_pwr_mgr;

   logic       clk;
   logic       rst_n;
   logic [1:0] Flt_n;
   logic       clr_latch;
   logic [1:0] sht_dwn;
   logic [1:0] amp_ok;
   logic [1:0] latched;
   logic [1:0] fault_evt;
   logic       mute;

   int n_checks = 0;
   int n_fail   = 0;

   amp_pwr_mgr #(
      .NUM_AMPS (2),
      .HOLD_CYC (20),
      .DEB_CYC  (4),
      .MAX_RETRY(2),
      .OK_CYC   (50)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Flt_n    (Flt_n),
      .clr_latch(clr_latch),
      .sht_dwn  (sht_dwn),
      .amp_ok   (amp_ok),
      .latched  (latched),
      .fault_evt(fault_evt),
      .mute     (mute)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, release, and let both channels reach RUN (20-edge hold).
   task automatic apply_reset();
      rst_n     = 1'b0;
      Flt_n     = 2'b11;
      clr_latch = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
   endtask

   // 8-cycle fault on the masked channels, then wait until a retried channel is back in RUN.
   task automatic fault_cycle(input logic [1:0] mask);
      Flt_n = ~mask;
      repeat (8) tick();
      Flt_n = 2'b11;
      repeat (23) tick();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      Flt_n     = 2'b11;
      clr_latch = 1'b0;
      tick();
      n_checks++;
      if ({sht_dwn, amp_ok, latched, fault_evt, mute} !== 9'b11_00_00_00_1) begin
         n_fail++;
         $display("FAIL reset_values: got sht=%b ok=%b lat=%b evt=%b mute=%b required sht=11 ok=00 lat=00 evt=00 mute=1",
                  sht_dwn, amp_ok, latched, fault_evt, mute);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         n_checks++;
         if (i < 20) begin
            if (sht_dwn !== 2'b11 || amp_ok !== 2'b00 || mute !== 1'b1) begin
               n_fail++;
               $display("FAIL powerup_hold edge %0d: got sht=%b ok=%b mute=%b required sht=11 ok=00 mute=1",
                        i, sht_dwn, amp_ok, mute);
            end
         end else begin
            if (sht_dwn !== 2'b00 || amp_ok !== 2'b11 || mute !== 1'b0) begin
               n_fail++;
               $display("FAIL powerup_release edge %0d: got sht=%b ok=%b mute=%b required sht=00 ok=11 mute=0",
                        i, sht_dwn, amp_ok, mute);
            end
         end
      end
   endtask

   task automatic test_glitch_and_fault();
      apply_reset();
      Flt_n = 2'b10;
      repeat (3) tick();
      Flt_n = 2'b11;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (sht_dwn !== 2'b00 || fault_evt !== 2'b00 || amp_ok !== 2'b11) begin
            n_fail++;
            $display("FAIL glitch_ignored cyc %0d: got sht=%b evt=%b ok=%b required sht=00 evt=00 ok=11",
                     i, sht_dwn, fault_evt, amp_ok);
         end
      end
      Flt_n = 2'b10;
      for (int t = 1; t <= 10; t++) begin
         tick();
         n_checks++;
         if (t < 7) begin
            if (sht_dwn !== 2'b00 || fault_evt !== 2'b00) begin
               n_fail++;
               $display("FAIL fault_latency t=%0d: got sht=%b evt=%b required sht=00 evt=00", t, sht_dwn, fault_evt);
            end
         end else if (t == 7) begin
            if (sht_dwn !== 2'b01 || fault_evt !== 2'b01 || mute !== 1'b1 || amp_ok !== 2'b10) begin
               n_fail++;
               $display("FAIL fault_accept t=%0d: got sht=%b evt=%b mute=%b ok=%b required sht=01 evt=01 mute=1 ok=10",
                        t, sht_dwn, fault_evt, mute, amp_ok);
            end
         end else begin
            if (sht_dwn !== 2'b01 || fault_evt !== 2'b00) begin
               n_fail++;
               $display("FAIL fault_single_pulse t=%0d: got sht=%b evt=%b required sht=01 evt=00", t, sht_dwn, fault_evt);
            end
         end
      end
      Flt_n = 2'b11;
      for (int t = 11; t <= 33; t++) begin
         tick();
         if (t == 32 || t == 33) begin
            n_checks++;
            if (sht_dwn !== ((t == 33) ? 2'b00 : 2'b01)) begin
               n_fail++;
               $display("FAIL fault_rehold t=%0d: got sht=%b required %b", t, sht_dwn, (t == 33) ? 2'b00 : 2'b01);
            end
         end
      end
   endtask

   task automatic test_latch_off();
      apply_reset();
      for (int f = 0; f < 3; f++) begin
         Flt_n = 2'b01;
         repeat (6) tick();
         tick();
         n_checks++;
         if (fault_evt !== 2'b10 || sht_dwn !== 2'b10) begin
            n_fail++;
            $display("FAIL latch_fault%0d: got evt=%b sht=%b required evt=10 sht=10", f, fault_evt, sht_dwn);
         end
         tick();
         Flt_n = 2'b11;
         repeat (23) tick();
         n_checks++;
         if (f < 2) begin
            if (sht_dwn !== 2'b00 || latched !== 2'b00) begin
               n_fail++;
               $display("FAIL latch_retry%0d: got sht=%b lat=%b required sht=00 lat=00", f, sht_dwn, latched);
            end
         end else begin
            if (latched !== 2'b10 || sht_dwn !== 2'b10 || amp_ok !== 2'b01) begin
               n_fail++;
               $display("FAIL latch_entered: got lat=%b sht=%b ok=%b required lat=10 sht=10 ok=01",
                        latched, sht_dwn, amp_ok);
            end
         end
      end
      Flt_n = 2'b01;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (fault_evt !== 2'b00) begin
            n_fail++;
            $display("FAIL latch_ignores_flt cyc %0d: got evt=%b required 00", i, fault_evt);
         end
      end
      Flt_n = 2'b11;
      repeat (80) tick();
      n_checks++;
      if (sht_dwn !== 2'b10 || latched !== 2'b10) begin
         n_fail++;
         $display("FAIL latch_holds: got sht=%b lat=%b required sht=10 lat=10", sht_dwn, latched);
      end
      clr_latch = 1'b1;
      tick();
      clr_latch = 1'b0;
      n_checks++;
      if (latched !== 2'b00 || sht_dwn !== 2'b10) begin
         n_fail++;
         $display("FAIL clr_to_hold: got lat=%b sht=%b required lat=00 sht=10", latched, sht_dwn);
      end
      repeat (19) tick();
      n_checks++;
      if (sht_dwn !== 2'b10) begin
         n_fail++;
         $display("FAIL clr_hold19: got sht=%b required 10", sht_dwn);
      end
      tick();
      n_checks++;
      if (sht_dwn !== 2'b00 || amp_ok !== 2'b11) begin
         n_fail++;
         $display("FAIL clr_release: got sht=%b ok=%b required sht=00 ok=11", sht_dwn, amp_ok);
      end
      fault_cycle(2'b10);
      n_checks++;
      if (latched !== 2'b00 || sht_dwn !== 2'b00) begin
         n_fail++;
         $display("FAIL clr_retry_reset: got lat=%b sht=%b required lat=00 sht=00", latched, sht_dwn);
      end
   endtask

   task automatic test_retry_decay();
      apply_reset();
      fault_cycle(2'b01);
      fault_cycle(2'b01);
      repeat (60) tick();
      fault_cycle(2'b01);
      fault_cycle(2'b01);
      n_checks++;
      if (latched !== 2'b00 || sht_dwn !== 2'b00 || amp_ok !== 2'b11) begin
         n_fail++;
         $display("FAIL retry_decay: got lat=%b sht=%b ok=%b required lat=00 sht=00 ok=11",
                  latched, sht_dwn, amp_ok);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      Flt_n = 2'b00;
      repeat (6) tick();
      tick();
      n_checks++;
      if (fault_evt !== 2'b11 || sht_dwn !== 2'b11 || mute !== 1'b1) begin
         n_fail++;
         $display("FAIL both_fault: got evt=%b sht=%b mute=%b required evt=11 sht=11 mute=1",
                  fault_evt, sht_dwn, mute);
      end
      tick();
      Flt_n = 2'b11;
      repeat (23) tick();
      n_checks++;
      if (amp_ok !== 2'b11 || mute !== 1'b0) begin
         n_fail++;
         $display("FAIL both_recover: got ok=%b mute=%b required ok=11 mute=0", amp_ok, mute);
      end
      clr_latch = 1'b1;
      tick();
      clr_latch = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (amp_ok !== 2'b11 || sht_dwn !== 2'b00 || latched !== 2'b00) begin
         n_fail++;
         $display("FAIL clr_in_run: got ok=%b sht=%b lat=%b required ok=11 sht=00 lat=00",
                  amp_ok, sht_dwn, latched);
      end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 19 || i == 20) begin
            n_checks++;
            if (sht_dwn !== ((i == 20) ? 2'b00 : 2'b11)) begin
               n_fail++;
               $display("FAIL midhold_restart edge %0d: got sht=%b required %b", i, sht_dwn,
                        (i == 20) ? 2'b00 : 2'b11);
            end
         end
      end
      fault_cycle(2'b10);
      fault_cycle(2'b10);
      fault_cycle(2'b10);
      n_checks++;
      if (latched !== 2'b10) begin
         n_fail++;
         $display("FAIL pre_reset_latch: got lat=%b required 10", latched);
      end
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({sht_dwn, amp_ok, latched, fault_evt, mute} !== 9'b11_00_00_00_1) begin
         n_fail++;
         $display("FAIL async_reset: got sht=%b ok=%b lat=%b evt=%b mute=%b required sht=11 ok=00 lat=00 evt=00 mute=1",
                  sht_dwn, amp_ok, latched, fault_evt, mute);
      end
      tick();
      rst_n = 1'b1;
      repeat (19) tick();
      n_checks++;
      if (sht_dwn !== 2'b11) begin
         n_fail++;
         $display("FAIL rerelease_hold: got sht=%b required 11", sht_dwn);
      end
      tick();
      n_checks++;
      if (sht_dwn !== 2'b00 || amp_ok !== 2'b11) begin
         n_fail++;
         $display("FAIL rerelease_run: got sht=%b ok=%b required sht=00 ok=11", sht_dwn, amp_ok);
      end
      fault_cycle(2'b10);
      n_checks++;
      if (latched !== 2'b00 || amp_ok !== 2'b11) begin
         n_fail++;
         $display("FAIL retry_cleared_by_reset: got lat=%b ok=%b required lat=00 ok=11", latched, amp_ok);
      end
   endtask

   initial begin
      test_reset();
      test_glitch_and_fault();
      test_latch_off();
      test_retry_decay();
      test_simultaneous();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
